// File: rtl/uart_pkg.sv
// Shared types and constants for the UART interrupt path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package uart_pkg;

    // Interrupt IDs as they appear in ISR[3:1], listed from highest to lowest priority
    localparam logic [2:0] ISR_ID_RLS  = 3'b011;
    localparam logic [2:0] ISR_ID_RDA  = 3'b010;
    localparam logic [2:0] ISR_ID_TOUT = 3'b110;
    localparam logic [2:0] ISR_ID_THRE = 3'b001;
    localparam logic [2:0] ISR_ID_MSR  = 3'b000;

    localparam logic [7:0] ISR_NONE = 8'hC1;

    // RX FIFO trigger levels selected by FCR[7:6]
    localparam int unsigned RX_TRIG_1  = 1;
    localparam int unsigned RX_TRIG_4  = 4;
    localparam int unsigned RX_TRIG_8  = 8;
    localparam int unsigned RX_TRIG_14 = 14;

    // What the register block receives: the ISR value and its update strobe
    typedef struct packed {
        logic [7:0] isr;
        logic       isr_valid;
    } intrpt_reg_write_t;

    // ISR byte: [7:6] FIFO-enabled flags, [5:4] zero, [3:1] ID, [0] active-low pending
    function automatic logic [7:0] isr_encode(input logic       fifo_en,
                                              input logic       pend,
                                              input logic [2:0] id);
        return {{2{fifo_en}}, 2'b00, id, ~pend};
    endfunction

endpackage

// File: rtl/uart_intrpt_ctrl_if.sv
// Register-block side of the interrupt controller: access strobes in, ISR/IRQ out.
// Latency: none, wiring only.
// Backpressure: none; strobes are single-cycle and always accepted.
interface uart_intrpt_ctrl_if;
    logic       obi_read_isr_i;   // ISR read strobe
    logic       obi_read_rhr_i;   // RHR read strobe
    logic       obi_write_thr_i;  // THR write strobe
    logic [7:0] isr_o;            // current ISR value
    logic       isr_valid_o;      // ISR changed this cycle
    logic       irq_o;            // interrupt request, active high

    modport master (
        output obi_read_isr_i, obi_read_rhr_i, obi_write_thr_i,
        input  isr_o, isr_valid_o, irq_o
    );

    modport slave (
        input  obi_read_isr_i, obi_read_rhr_i, obi_write_thr_i,
        output isr_o, isr_valid_o, irq_o
    );
endinterface

// File: rtl/uart_rx_timeout.sv
// RX character-timeout detector: counts baud ticks while RX data sits idle for 4 frame times.
// Latency: tout_pend_nxt_o is the combinational next value of the pending flag.
// Backpressure: none; counter clears on any RX activity or an empty FIFO.
// Ports: clk_i/rst_ni, lcr_i[3:0] frame format, rx_level_i, rx_push_i, read_rhr_i,
//        baud_tick_i in; tout_pend_nxt_o out.
module uart_rx_timeout #(
    parameter int unsigned Oversample = 16,
    parameter int unsigned ToutWidth  = 10,
    parameter int unsigned LvlW       = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [3:0]      lcr_i,
    input  logic [LvlW-1:0] rx_level_i,
    input  logic            rx_push_i,
    input  logic            read_rhr_i,
    input  logic            baud_tick_i,
    output logic            tout_pend_nxt_o
);

    logic [ToutWidth-1:0] r_cnt;
    logic                 r_tout_pend;
    logic [ToutWidth-1:0] w_cnt_nxt;
    logic [ToutWidth-1:0] w_limit;
    logic [3:0]           w_frame;
    logic                 w_clr;
    logic                 w_hit;

    // Bits per frame: start + (5+word_len) data + parity + (1+stop_bits) stop
    assign w_frame = 4'd1 + (4'd5 + {2'b00, lcr_i[1:0]}) + {3'b000, lcr_i[3]}
                   + (4'd1 + {3'b000, lcr_i[2]});
    assign w_limit = ToutWidth'((4 * Oversample) * int'(w_frame) - 1);

    assign w_clr = (rx_level_i == '0) | rx_push_i | read_rhr_i;
    // The tick that arrives with the counter already at the limit fires the timeout;
    // '>=' covers an LCR change that shortens the limit below the current count.
    assign w_hit = baud_tick_i & (r_cnt >= w_limit);

    always_comb begin
        w_cnt_nxt       = r_cnt;
        tout_pend_nxt_o = r_tout_pend;
        if (w_clr) begin
            w_cnt_nxt       = '0;
            tout_pend_nxt_o = 1'b0;
        end else begin
            if (baud_tick_i && (r_cnt < w_limit)) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            if (w_hit) begin
                tout_pend_nxt_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_tout_pend <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_tout_pend <= tout_pend_nxt_o;
        end
    end

endmodule

// File: rtl/uart_intrpt_ctrl.sv
// 16550 interrupt scheduler: masks five sources with IER, picks by fixed priority, drives ISR/IRQ.
// Latency: isr_o/irq_o registered, one cycle after any input change.
// Backpressure: none; ISR read only clears a reported THRE and returns the pre-clear value.
// Ports: clk_i/rst_ni; ier_i, fifo_en_i, rx_fifo_tl_i, lcr_i config; lsr_err_i, rx_level_i,
//        rx_push_i, tx_empty_i, msr_delta_i, baud_tick_i status; bus carries strobes and ISR/IRQ.
module uart_intrpt_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FifoDepth  = 16,
    parameter int unsigned Oversample = 16,
    parameter int unsigned ToutWidth  = 10,
    localparam int unsigned LvlW      = $clog2(FifoDepth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           ier_i,
    input  logic                 fifo_en_i,
    input  logic [1:0]           rx_fifo_tl_i,
    input  logic [7:0]           lcr_i,
    input  logic [3:0]           lsr_err_i,
    input  logic [LvlW-1:0]      rx_level_i,
    input  logic                 rx_push_i,
    input  logic                 tx_empty_i,
    input  logic [3:0]           msr_delta_i,
    input  logic                 baud_tick_i,
    uart_intrpt_ctrl_if.slave    bus
);

    intrpt_reg_write_t r_isr_wr;
    logic              r_irq;
    logic              r_thre_pend;
    logic              r_tx_empty_q;
    logic              r_ier_thre_q;

    logic [LvlW-1:0]   w_trig;
    logic              w_rda;
    logic              w_tout_nxt;
    logic              w_thre_set;
    logic              w_thre_isr_clr;
    logic              w_thre_nxt;
    logic              w_pend;
    logic [2:0]        w_id;
    logic [7:0]        w_isr_nxt;
    logic              w_unused_bits;

    assign w_unused_bits = ^{ier_i[7:4], lcr_i[7:4]};

    always_comb begin
        w_trig = LvlW'(RX_TRIG_1);
        if (fifo_en_i) begin
            case (rx_fifo_tl_i)
                2'b00:   w_trig = LvlW'(RX_TRIG_1);
                2'b01:   w_trig = LvlW'(RX_TRIG_4);
                2'b10:   w_trig = LvlW'(RX_TRIG_8);
                default: w_trig = LvlW'(RX_TRIG_14);
            endcase
        end
    end

    assign w_rda = (rx_level_i >= w_trig);

    uart_rx_timeout #(
        .Oversample (Oversample),
        .ToutWidth  (ToutWidth),
        .LvlW       (LvlW)
    ) u_rx_timeout (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .lcr_i           (lcr_i[3:0]),
        .rx_level_i      (rx_level_i),
        .rx_push_i       (rx_push_i),
        .read_rhr_i      (bus.obi_read_rhr_i),
        .baud_tick_i     (baud_tick_i),
        .tout_pend_nxt_o (w_tout_nxt)
    );

    // THRE latches on THR becoming empty, or on the interrupt being enabled while already empty
    assign w_thre_set     = (tx_empty_i & ~r_tx_empty_q) | (ier_i[1] & ~r_ier_thre_q & tx_empty_i);
    assign w_thre_isr_clr = bus.obi_read_isr_i & ~r_isr_wr.isr[0] & (r_isr_wr.isr[3:1] == ISR_ID_THRE);

    // THR write beats a new set; a new set beats the ISR-read clear
    always_comb begin
        w_thre_nxt = r_thre_pend;
        if (bus.obi_write_thr_i) begin
            w_thre_nxt = 1'b0;
        end else if (w_thre_set) begin
            w_thre_nxt = 1'b1;
        end else if (w_thre_isr_clr) begin
            w_thre_nxt = 1'b0;
        end
    end

    // Arbitration uses next-state pending flags so every source reaches ISR in one cycle
    always_comb begin
        w_pend = 1'b0;
        w_id   = ISR_ID_MSR;
        if (ier_i[2] && (|lsr_err_i)) begin
            w_pend = 1'b1;
            w_id   = ISR_ID_RLS;
        end else if (ier_i[0] && w_rda) begin
            w_pend = 1'b1;
            w_id   = ISR_ID_RDA;
        end else if (ier_i[0] && fifo_en_i && w_tout_nxt) begin
            w_pend = 1'b1;
            w_id   = ISR_ID_TOUT;
        end else if (ier_i[1] && w_thre_nxt) begin
            w_pend = 1'b1;
            w_id   = ISR_ID_THRE;
        end else if (ier_i[3] && (|msr_delta_i)) begin
            w_pend = 1'b1;
            w_id   = ISR_ID_MSR;
        end
    end

    assign w_isr_nxt = isr_encode(fifo_en_i, w_pend, w_id);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_isr_wr     <= '{isr: ISR_NONE, isr_valid: 1'b0};
            r_irq        <= 1'b0;
            r_thre_pend  <= 1'b0;
            r_tx_empty_q <= 1'b0;
            r_ier_thre_q <= 1'b0;
        end else begin
            r_isr_wr.isr       <= w_isr_nxt;
            r_isr_wr.isr_valid <= (w_isr_nxt != r_isr_wr.isr);
            r_irq              <= ~w_isr_nxt[0];
            r_thre_pend        <= w_thre_nxt;
            r_tx_empty_q       <= tx_empty_i;
            r_ier_thre_q       <= ier_i[1];
        end
    end

    assign bus.isr_o       = r_isr_wr.isr;
    assign bus.isr_valid_o = r_isr_wr.isr_valid;
    assign bus.irq_o       = r_irq;

endmodule

// File: tb/tb_uart_intrpt_ctrl.sv
// Directed bench for uart_intrpt_ctrl: priority, trigger levels, timeout, THRE edge cases, reset.
// Latency: checks sample 1 time unit after the clock edge that registers the inputs.
// Backpressure: not applicable.
module tb_uart_intrpt_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] ier_i;
    logic       fifo_en_i;
    logic [1:0] rx_fifo_tl_i;
    logic [7:0] lcr_i;
    logic [3:0] lsr_err_i;
    logic [4:0] rx_level_i;
    logic       rx_push_i;
    logic       tx_empty_i;
    logic [3:0] msr_delta_i;
    logic       baud_tick_i;

    int total = 0;
    int bad   = 0;

    uart_intrpt_ctrl_if u_if ();

    uart_intrpt_ctrl #(
        .FifoDepth  (16),
        .Oversample (16),
        .ToutWidth  (10)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ier_i        (ier_i),
        .fifo_en_i    (fifo_en_i),
        .rx_fifo_tl_i (rx_fifo_tl_i),
        .lcr_i        (lcr_i),
        .lsr_err_i    (lsr_err_i),
        .rx_level_i   (rx_level_i),
        .rx_push_i    (rx_push_i),
        .tx_empty_i   (tx_empty_i),
        .msr_delta_i  (msr_delta_i),
        .baud_tick_i  (baud_tick_i),
        .bus          (u_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni                = 1'b0;
        ier_i                 = 8'h00;
        fifo_en_i             = 1'b0;
        rx_fifo_tl_i          = 2'b00;
        lcr_i                 = 8'h03;
        lsr_err_i             = 4'h0;
        rx_level_i            = 5'd0;
        rx_push_i             = 1'b0;
        tx_empty_i            = 1'b0;
        msr_delta_i           = 4'h0;
        baud_tick_i           = 1'b0;
        u_if.obi_read_isr_i   = 1'b0;
        u_if.obi_read_rhr_i   = 1'b0;
        u_if.obi_write_thr_i  = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        // ---- Reset state and THRE via IER enable
        do_reset();
        chk("rst_isr", u_if.isr_o, 8'hC1);
        chk("rst_vld", u_if.isr_valid_o, 1'b0);
        chk("rst_irq", u_if.irq_o, 1'b0);
        tx_empty_i = 1'b1;
        step();
        chk("t1_idle", u_if.isr_o, 8'h01);
        ier_i = 8'h02;
        step();
        chk("t1_thre", u_if.isr_o, 8'h02);
        chk("t1_irq", u_if.irq_o, 1'b1);
        chk("t1_vld", u_if.isr_valid_o, 1'b1);
        step();
        chk("t1_vld_drop", u_if.isr_valid_o, 1'b0);
        u_if.obi_read_isr_i = 1'b1;
        step();
        u_if.obi_read_isr_i = 1'b0;
        chk("t1_rd_clr", u_if.isr_o, 8'h01);
        chk("t1_rd_irq", u_if.irq_o, 1'b0);

        // ---- RDA trigger level 4
        do_reset();
        fifo_en_i    = 1'b1;
        rx_fifo_tl_i = 2'b01;
        ier_i        = 8'h01;
        for (int i = 1; i <= 3; i++) begin
            rx_level_i = 5'(i);
            rx_push_i  = 1'b1;
            step();
        end
        rx_push_i = 1'b0;
        step();
        chk("t2_lvl3", u_if.isr_o, 8'hC1);
        rx_level_i = 5'd4;
        rx_push_i  = 1'b1;
        step();
        rx_push_i = 1'b0;
        chk("t2_lvl4", u_if.isr_o, 8'hC4);
        chk("t2_irq", u_if.irq_o, 1'b1);
        rx_level_i = 5'd3;
        step();
        chk("t2_drop", u_if.isr_o, 8'hC1);

        // ---- Character timeout, 8N1 -> 640 ticks
        do_reset();
        fifo_en_i    = 1'b1;
        rx_fifo_tl_i = 2'b01;
        ier_i        = 8'h01;
        lcr_i        = 8'h03;
        rx_level_i   = 5'd1;
        rx_push_i    = 1'b1;
        step();
        rx_push_i   = 1'b0;
        baud_tick_i = 1'b1;
        repeat (639) step();
        chk("t3_639", u_if.isr_o, 8'hC1);
        step();
        baud_tick_i = 1'b0;
        chk("t3_640", u_if.isr_o, 8'hCC);
        step();
        chk("t3_hold", u_if.isr_o, 8'hCC);
        u_if.obi_read_rhr_i = 1'b1;
        step();
        u_if.obi_read_rhr_i = 1'b0;
        chk("t3_rhr", u_if.isr_o, 8'hC1);

        // ---- Priority walk
        do_reset();
        fifo_en_i    = 1'b1;
        rx_fifo_tl_i = 2'b00;
        ier_i        = 8'h0F;
        lsr_err_i    = 4'b0001;
        rx_level_i   = 5'd2;
        msr_delta_i  = 4'b0010;
        tx_empty_i   = 1'b1;
        step();
        chk("t4_rls", u_if.isr_o, 8'hC6);
        lsr_err_i = 4'h0;
        step();
        chk("t4_rda", u_if.isr_o, 8'hC4);
        rx_level_i = 5'd0;
        step();
        chk("t4_thre", u_if.isr_o, 8'hC2);
        u_if.obi_write_thr_i = 1'b1;
        step();
        u_if.obi_write_thr_i = 1'b0;
        chk("t4_msr", u_if.isr_o, 8'hC0);
        step();
        chk("t4_msr_hold", u_if.isr_o, 8'hC0);
        msr_delta_i = 4'h0;
        step();
        chk("t4_none", u_if.isr_o, 8'hC1);
        chk("t4_irq", u_if.irq_o, 1'b0);

        // ---- THRE set/clear collisions and IER masking
        do_reset();
        ier_i = 8'h02;
        step();
        chk("t5_idle", u_if.isr_o, 8'h01);
        tx_empty_i = 1'b1;
        step();
        chk("t5_set", u_if.isr_o, 8'h02);
        tx_empty_i = 1'b0;
        step();
        chk("t5_retain", u_if.isr_o, 8'h02);
        u_if.obi_read_isr_i = 1'b1;
        tx_empty_i          = 1'b1;
        step();
        u_if.obi_read_isr_i = 1'b0;
        chk("t5_set_wins", u_if.isr_o, 8'h02);
        chk("t5_no_vld", u_if.isr_valid_o, 1'b0);
        tx_empty_i = 1'b0;
        ier_i      = 8'h00;
        step();
        chk("t5_masked", u_if.isr_o, 8'h01);
        ier_i = 8'h02;
        step();
        chk("t5_unmask", u_if.isr_o, 8'h02);
        u_if.obi_write_thr_i = 1'b1;
        tx_empty_i           = 1'b1;
        step();
        u_if.obi_write_thr_i = 1'b0;
        chk("t5_wr_wins", u_if.isr_o, 8'h01);

        // ---- Async reset in mid-count
        do_reset();
        fifo_en_i    = 1'b1;
        rx_fifo_tl_i = 2'b01;
        ier_i        = 8'h09;
        msr_delta_i  = 4'b0001;
        rx_level_i   = 5'd1;
        rx_push_i    = 1'b1;
        step();
        rx_push_i   = 1'b0;
        baud_tick_i = 1'b1;
        repeat (300) step();
        baud_tick_i = 1'b0;
        chk("t6_pre", u_if.isr_o, 8'hC0);
        #2;
        rst_ni      = 1'b0;
        msr_delta_i = 4'h0;
        ier_i       = 8'h01;
        #1;
        chk("t6_rst_isr", u_if.isr_o, 8'hC1);
        chk("t6_rst_irq", u_if.irq_o, 1'b0);
        step();
        rst_ni      = 1'b1;
        baud_tick_i = 1'b1;
        repeat (639) step();
        chk("t6_639", u_if.isr_o, 8'hC1);
        step();
        baud_tick_i = 1'b0;
        chk("t6_640", u_if.isr_o, 8'hCC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_intrpt_ctrl.md
Name: uart_intrpt_ctrl

Overview:
Interrupt scheduler for the 16550A-compatible UART. It collects the five interrupt sources: receiver line status, RX data available, character timeout, THR empty and modem status. It masks them with IER, arbitrates by fixed 16550 priority, and drives the ISR contents plus the external interrupt line. It sits between the RX/TX/modem logic and the register block, and its ISR output is packed into intrpt_reg_write_t.

Parameters:
FifoDepth, 16, RX FIFO depth; sets the width of rx_level_i.
Oversample, 16, baud ticks per bit time.
ToutWidth, 10, timeout counter width; must hold 4*12*Oversample-1.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ier_i  in  8  IER: [0] rda, [1] thre, [2] rls, [3] msr
fifo_en_i  in  1  FCR.fifo_en
rx_fifo_tl_i  in  2  FCR trigger level
lcr_i  in  8  LCR: [1:0] word_len, [2] stop_bits, [3] par_en
lsr_err_i  in  4  {break, frame, parity, overrun} status bits as held in LSR
rx_level_i  in  $clog2(FifoDepth)+1  RX FIFO fill level
rx_push_i  in  1  a character was written into the RX FIFO
tx_empty_i  in  1  TX FIFO/THR empty
msr_delta_i  in  4  MSR delta bits {d_cd, te_ri, d_dsr, d_cts}
baud_tick_i  in  1  oversample tick
obi_read_isr_i  in  1  ISR read strobe (1 cycle)
obi_read_rhr_i  in  1  RHR read strobe
obi_write_thr_i  in  1  THR write strobe
isr_o  out  8  ISR value
isr_valid_o  out  1  ISR update strobe for the register block
irq_o  out  1  interrupt request, active high

Behaviour:
- Reset: isr_o=8'hC1, isr_valid_o=0, irq_o=0, thre_pend=0, timeout counter=0, tout_pend=0.
- ISR encoding:
  - isr_o[0]=1 means no interrupt pending.
  - isr_o[3:1] is the ID.
  - isr_o[5:4]=0.
  - isr_o[7:6]=2'b11 if fifo_en_i, else 2'b00.
- Priority, highest first; a source is enabled only if its IER bit is set:
  - RLS, ID 3'b011: |lsr_err_i, enabled by ier[2]. Level-based; clears when LSR is read, because LSR clears its own bits.
  - RDA, ID 3'b010: rx_level_i >= trig, enabled by ier[0].
    - trig is 1/4/8/14 for tl 00/01/10/11.
    - trig=1 when fifo_en_i=0.
    - Level-based.
  - Timeout, ID 3'b110: tout_pend, enabled by ier[0]. Only when fifo_en_i=1.
  - THRE, ID 3'b001: thre_pend, enabled by ier[1].
  - MSR, ID 3'b000: |msr_delta_i, enabled by ier[3].
- Timeout counter (sub-module):
  - Clears when rx_level_i==0, on rx_push_i, or on obi_read_rhr_i.
  - Otherwise increments on each baud_tick_i.
  - Limit = 4*Oversample*F-1, where F = 1+(5+word_len)+par_en+(1+stop_bits).
  - At the limit, tout_pend sets and the counter saturates.
  - tout_pend clears on obi_read_rhr_i, rx_push_i, or rx_level_i==0.
- thre_pend:
  - Sets on a tx_empty_i rising edge.
  - Sets on an ier[1] rising edge while tx_empty_i=1.
  - Clears on obi_write_thr_i.
  - Clears on obi_read_isr_i when the currently reported ID is 3'b001.
  - Simultaneous set and clear: set wins over an ISR-read clear; a THR write wins over a set.
- Timing:
  - isr_o and irq_o are registered, with 1-cycle latency from any input change.
  - isr_valid_o pulses for 1 cycle whenever the next isr_o differs from the current one.
  - irq_o = ~next isr[0].
- ISR read side effect: only the THRE clear; the read returns the pre-clear value.
- IER cleared while a source is pending: that ID drops out on the next cycle; the pending flags are retained.

Decomposition:
- uart_pkg gets the following; intrpt_reg_write_t is reused at top level as {isr_o, isr_valid_o}:
  - ISR_ID_RLS=3'b011, ISR_ID_RDA=3'b010, ISR_ID_TOUT=3'b110, ISR_ID_THRE=3'b001, ISR_ID_MSR=3'b000.
  - ISR_NONE=8'hC1.
  - Trigger-level constants 1/4/8/14.
- One sub-module: uart_rx_timeout, which holds the counter, the frame-length computation and tout_pend.

Test Plan:
1. Reset, then ier=8'h02 with tx_empty_i=1 → after 1 cycle isr_o=8'h02 (no FIFO) and irq_o=1. Pulse obi_read_isr_i → isr_o=8'h01, irq_o=0.
2. FIFO on (fifo_en=1), tl=2'b01, ier=8'h01; push 3 chars → isr_o=8'hC1. Push a 4th → isr_o=8'hC4; with level dropping to 3, isr_o returns to 8'hC1.
3. lcr=8'h03 (8N1, F=10); 1 char in FIFO, ier=8'h01; 639 baud ticks → no interrupt. Tick 640 → isr_o=8'hCC. obi_read_rhr_i → isr_o=8'hC1 next cycle.
4. RLS, RDA, THRE and MSR all pending, ier=8'h0F → ID 011. Clear lsr_err → ID 010. Drain RX → ID 001. Write THR → ID 000. Clear delta → 8'hC1.
5. Simultaneous obi_read_isr_i (reporting THRE) and a tx_empty_i rising edge → thre_pend stays 1, isr_o stays 8'h02.
6. Assert rst_ni low mid-timeout count → isr_o=8'hC1 and irq_o=0 asynchronously. After release, a full new limit of 640 ticks is needed to set the timeout.
